// File: rtl/nibble_sub_stream.sv
// Streaming multi-beat subtractor: diff = A - B - borrow, LSB slice first.
// Optional SUB_BORROW_CNT_EN adds a saturating negative-word counter.
module nibble_sub_stream #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_bin,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_diff,
  output logic             out_bout,
  output logic             out_last
`ifdef SUB_BORROW_CNT_EN
  ,
  output logic [7:0]       ovf_count
`endif
);

  typedef enum logic {FIRST, MID} state_t;

  state_t           state_q, state_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
  logic             last_q, last_d;
  logic             borrow_q, borrow_d;

  logic             accept;
  logic             bsel;
  logic [WIDTH:0]   sub;

  assign in_ready = ~valid_q | out_ready;
  assign accept   = in_valid & in_ready;
  assign bsel     = (state_q == FIRST) ? in_bin : borrow_q;
  assign sub      = {1'b0, in_a} - {1'b0, in_b}
                  - {{WIDTH{1'b0}}, bsel};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= FIRST;
      valid_q  <= 1'b0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
      last_q   <= 1'b0;
      borrow_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      valid_q  <= valid_d;
      diff_q   <= diff_d;
      bout_q   <= bout_d;
      last_q   <= last_d;
      borrow_q <= borrow_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    valid_d  = valid_q;
    diff_d   = diff_q;
    bout_d   = bout_q;
    last_d   = last_q;
    borrow_d = borrow_q;
    if (accept) begin
      valid_d  = 1'b1;
      diff_d   = sub[WIDTH-1:0];
      bout_d   = sub[WIDTH];
      last_d   = in_last;
      borrow_d = sub[WIDTH];
      unique case (state_q)
        FIRST: state_d = in_last ? FIRST : MID;
        MID:   state_d = in_last ? FIRST : MID;
        default: state_d = FIRST;
      endcase
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  assign out_valid = valid_q;
  assign out_diff  = diff_q;
  assign out_bout  = bout_q;
  assign out_last  = last_q;

`ifdef SUB_BORROW_CNT_EN
  logic [7:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= 8'd0;
    else        cnt_q <= cnt_d;
  end

  // Counts negative word results; holds at 255.
  always_comb begin
    cnt_d = cnt_q;
    if (accept && in_last && sub[WIDTH] && cnt_q != 8'hFF)
      cnt_d = cnt_q + 8'd1;
  end

  assign ovf_count = cnt_q;
`endif

endmodule

// File: tb/tb_nibble_sub_stream.sv
// Directed bench for nibble_sub_stream (WIDTH = 4).
// Build with +define+SUB_BORROW_CNT_EN to cover the counter too.
module tb_nibble_sub_stream;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_a;
  logic [3:0] in_b;
  logic       in_bin;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_diff;
  logic       out_bout;
  logic       out_last;
`ifdef SUB_BORROW_CNT_EN
  logic [7:0] ovf_count;
  int         exp_cnt;
`endif

  int total;
  int bad;

  nibble_sub_stream #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_bin    (in_bin),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_diff  (out_diff),
    .out_bout  (out_bout),
    .out_last  (out_last)
`ifdef SUB_BORROW_CNT_EN
    ,
    .ovf_count (ovf_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       bin;
    logic       last;
    logic [3:0] diff;
    logic       bout;
  } vec_t;

  vec_t single_v[8];
  vec_t word_v[4];

  task automatic chk(input string name, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, got, exp);
    end
  endtask

  // Present one beat, take the edge, sample 1 ns later.
  task automatic beat(input logic [3:0] a, input logic [3:0] b,
                      input logic bin, input logic last);
    in_a     = a;
    in_b     = b;
    in_bin   = bin;
    in_last  = last;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string name, input logic [3:0] d,
                         input logic bo, input logic l);
    chk({name, ".valid"}, int'(out_valid), 1);
    chk({name, ".diff"}, int'(out_diff), int'(d));
    chk({name, ".bout"}, int'(out_bout), int'(bo));
    chk({name, ".last"}, int'(out_last), int'(l));
  endtask

  task automatic idle_cycle();
    in_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst.valid", int'(out_valid), 0);
    chk("rst.diff", int'(out_diff), 0);
    chk("rst.bout", int'(out_bout), 0);
    chk("rst.last", int'(out_last), 0);
`ifdef SUB_BORROW_CNT_EN
    chk("rst.ovf", int'(ovf_count), 0);
    exp_cnt = 0;
`endif
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Reset after beat 1 of a 4-beat word; next beat must be a FIRST beat.
  task automatic reset_mid(input logic bin, input logic [3:0] d);
    out_ready = 1'b1;
    beat(4'h0, 4'h1, 1'b0, 1'b0);
    beat(4'h0, 4'h0, 1'b0, 1'b0);
    chk_out("rmid.b1", 4'hF, 1'b1, 1'b0);
    in_valid = 1'b0;
    do_reset();
    beat(4'h5, 4'h2, bin, 1'b1);
    chk_out("rmid.next", d, 1'b0, 1'b1);
    idle_cycle();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    single_v[0] = '{4'h9, 4'h3, 1'b0, 1'b1, 4'h6, 1'b0};
    single_v[1] = '{4'h9, 4'h3, 1'b1, 1'b1, 4'h5, 1'b0};
    single_v[2] = '{4'h0, 4'h1, 1'b0, 1'b1, 4'hF, 1'b1};
    single_v[3] = '{4'h7, 4'h7, 1'b1, 1'b1, 4'hF, 1'b1};
    single_v[4] = '{4'hF, 4'h0, 1'b1, 1'b1, 4'hE, 1'b0};
    single_v[5] = '{4'h8, 4'h8, 1'b0, 1'b1, 4'h0, 1'b0};
    single_v[6] = '{4'h0, 4'hF, 1'b1, 1'b1, 4'h0, 1'b1};
    single_v[7] = '{4'h5, 4'hA, 1'b0, 1'b1, 4'hB, 1'b1};
    // 0x1000 - 0x0001; in_bin high on beats 1-3 must be ignored.
    word_v[0] = '{4'h0, 4'h1, 1'b0, 1'b0, 4'hF, 1'b1};
    word_v[1] = '{4'h0, 4'h0, 1'b1, 1'b0, 4'hF, 1'b1};
    word_v[2] = '{4'h0, 4'h0, 1'b1, 1'b0, 4'hF, 1'b1};
    word_v[3] = '{4'h1, 4'h0, 1'b1, 1'b1, 4'h0, 1'b0};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_bin    = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    #2;
    do_reset();

    // Back-to-back single-beat words.
    for (int i = 0; i < 8; i++) begin
      beat(single_v[i].a, single_v[i].b, single_v[i].bin, 1'b1);
      chk_out($sformatf("single%0d", i), single_v[i].diff,
              single_v[i].bout, 1'b1);
`ifdef SUB_BORROW_CNT_EN
      if (single_v[i].bout) exp_cnt++;
      chk($sformatf("single%0d.ovf", i), int'(ovf_count), exp_cnt);
`endif
    end
    idle_cycle();
    chk("drain.valid", int'(out_valid), 0);

    // Four-beat word at full throughput.
    for (int i = 0; i < 4; i++) begin
      beat(word_v[i].a, word_v[i].b, word_v[i].bin, word_v[i].last);
      chk_out($sformatf("word%0d", i), word_v[i].diff,
              word_v[i].bout, word_v[i].last);
    end

    // Word ending negative, then a fresh word must use in_bin again.
    beat(4'h0, 4'h1, 1'b0, 1'b0);
    chk_out("neg.b0", 4'hF, 1'b1, 1'b0);
    beat(4'h0, 4'h0, 1'b0, 1'b1);
    chk_out("neg.b1", 4'hF, 1'b1, 1'b1);
    beat(4'h5, 4'h2, 1'b0, 1'b1);
    chk_out("neg.next", 4'h3, 1'b0, 1'b1);
    idle_cycle();

    // Backpressure: output holds and input is refused.
    beat(4'h9, 4'h3, 1'b0, 1'b1);
    chk_out("bp.first", 4'h6, 1'b0, 1'b1);
    out_ready = 1'b0;
    in_a      = 4'h4;
    in_b      = 4'h1;
    #1;
    chk("bp.ready0", int'(in_ready), 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk_out($sformatf("bp.hold%0d", i), 4'h6, 1'b0, 1'b1);
      chk($sformatf("bp.ready%0d", i + 1), int'(in_ready), 0);
    end
    out_ready = 1'b1;
    #1;
    chk("bp.ready_up", int'(in_ready), 1);
    @(posedge clk);
    #1;
    chk_out("bp.next", 4'h3, 1'b0, 1'b1);
    idle_cycle();
    chk("bp.drain", int'(out_valid), 0);

    reset_mid(1'b0, 4'h3);
    reset_mid(1'b1, 4'h2);

`ifdef SUB_BORROW_CNT_EN
    do_reset();
    beat(4'h0, 4'h1, 1'b0, 1'b1);
    chk("wrap.ovf", int'(ovf_count), 1);
    for (int i = 1; i < 300; i++) beat(4'h0, 4'h1, 1'b0, 1'b1);
    idle_cycle();
    chk("sat.ovf", int'(ovf_count), 255);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
